multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 67 ++++++
 rtl/multicycle_ctrl_if.sv | 38 +++
 rtl/mc_wait_timer.sv | 31 +++
 rtl/multicycle_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V controller.
// Optional feature macro: ILLEGAL_TRAP_EN adds the TRAP state.
package ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OP_W     = 7;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned IMM_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALR_WB  = 4'd12,
    S_LUI      = 4'd13
`ifdef ILLEGAL_TRAP_EN
    ,
    S_TRAP     = 4'd14
`endif
  } state_e;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

  localparam logic [SEL_W-1:0] ALU_A_PC    = 2'b00;
  localparam logic [SEL_W-1:0] ALU_A_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] ALU_A_RS1   = 2'b10;
  localparam logic [SEL_W-1:0] ALU_A_ZERO  = 2'b11;

  localparam logic [SEL_W-1:0] ALU_B_RS2   = 2'b00;
  localparam logic [SEL_W-1:0] ALU_B_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] ALU_B_FOUR  = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALUOUT  = 2'b00;
  localparam logic [SEL_W-1:0] RES_MEM     = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU     = 2'b10;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [IMM_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_W-1:0] IMM_U = 3'b100;

  // States that stall on the memory handshake
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle.
interface multicycle_ctrl_if;
  import ctrl_pkg::*;

  logic [OP_W-1:0]    op_i;
  logic               zero_i;
  logic               mem_ready_i;
  logic               pc_write_o;
  logic               ir_write_o;
  logic               reg_write_o;
  logic               mem_read_o;
  logic               mem_write_o;
  logic               adr_src_o;
  logic [SEL_W-1:0]   alu_src_a_o;
  logic [SEL_W-1:0]   alu_src_b_o;
  logic [SEL_W-1:0]   alu_op_o;
  logic [IMM_W-1:0]   imm_src_o;
  logic [SEL_W-1:0]   result_src_o;
  logic [STATE_W-1:0] state_o;
  logic               illegal_o;
  logic               mem_err_o;

  // Controller side
  modport master (
    input  op_i, zero_i, mem_ready_i,
    output pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o,
           adr_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, imm_src_o,
           result_src_o, state_o, illegal_o, mem_err_o
  );

  // Datapath / memory side
  modport slave (
    output op_i, zero_i, mem_ready_i,
    input  pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o,
           adr_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, imm_src_o,
           result_src_o, state_o, illegal_o, mem_err_o
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Saturating memory-wait counter; flag_o is high while the count sits at WAIT_MAX.
// WAIT_MAX is expected to be at least 1.
module mc_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic flag_o
);

  localparam int unsigned CNT_W = (WAIT_MAX <= 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

  logic [CNT_W-1:0] cnt_q;

  // Count held cycles, clear on request, stop at the limit
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign flag_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RISC-V control FSM (FETCH/DECODE/execute/writeback).
// Define ILLEGAL_TRAP_EN to park unknown opcodes in a TRAP state.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  multicycle_ctrl_if.master    bus
);

  state_e state_q, state_d;
  logic   wait_flag;
  logic   err_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_EXEC_R;
`endif
        endcase
      end
      S_MEMADR:   state_d = (bus.op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.mem_ready_i) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready_i) state_d = S_FETCH;
      S_EXEC_R,
      S_EXEC_I,
      S_LUI,
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JALR:     state_d = S_JALR_WB;
      S_JALR_WB:  state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Datapath control decode from the current state
  always_comb begin
    bus.pc_write_o   = 1'b0;
    bus.ir_write_o   = 1'b0;
    bus.reg_write_o  = 1'b0;
    bus.mem_read_o   = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.adr_src_o    = 1'b0;
    bus.alu_src_a_o  = ALU_A_PC;
    bus.alu_src_b_o  = ALU_B_RS2;
    bus.alu_op_o     = ALUOP_ADD;
    bus.imm_src_o    = IMM_I;
    bus.result_src_o = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        bus.mem_read_o   = 1'b1;
        bus.alu_src_a_o  = ALU_A_PC;
        bus.alu_src_b_o  = ALU_B_FOUR;
        bus.result_src_o = RES_ALU;
        bus.ir_write_o   = bus.mem_ready_i;
        bus.pc_write_o   = bus.mem_ready_i;
      end
      S_DECODE: begin
        bus.alu_src_a_o = ALU_A_OLDPC;
        bus.alu_src_b_o = ALU_B_IMM;
        bus.imm_src_o   = IMM_B;
      end
      S_MEMADR: begin
        bus.alu_src_a_o = ALU_A_RS1;
        bus.alu_src_b_o = ALU_B_IMM;
        bus.imm_src_o   = (bus.op_i == OP_LOAD) ? IMM_I : IMM_S;
      end
      S_MEMREAD: begin
        bus.mem_read_o = 1'b1;
        bus.adr_src_o  = 1'b1;
      end
      S_MEMWB: begin
        bus.result_src_o = RES_MEM;
        bus.reg_write_o  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.mem_write_o = 1'b1;
        bus.adr_src_o   = 1'b1;
      end
      S_EXEC_R: begin
        bus.alu_src_a_o = ALU_A_RS1;
        bus.alu_src_b_o = ALU_B_RS2;
        bus.alu_op_o    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        bus.alu_src_a_o = ALU_A_RS1;
        bus.alu_src_b_o = ALU_B_IMM;
        bus.imm_src_o   = IMM_I;
        bus.alu_op_o    = ALUOP_FUNCT;
      end
      S_LUI: begin
        bus.alu_src_a_o = ALU_A_ZERO;
        bus.alu_src_b_o = ALU_B_IMM;
        bus.imm_src_o   = IMM_U;
      end
      S_ALUWB: begin
        bus.result_src_o = RES_ALUOUT;
        bus.reg_write_o  = 1'b1;
      end
      S_BEQ: begin
        bus.alu_src_a_o = ALU_A_RS1;
        bus.alu_src_b_o = ALU_B_RS2;
        bus.alu_op_o    = ALUOP_SUB;
        bus.pc_write_o  = bus.zero_i;
      end
      S_JAL: begin
        bus.alu_src_a_o = ALU_A_OLDPC;
        bus.alu_src_b_o = ALU_B_FOUR;
        bus.pc_write_o  = 1'b1;
      end
      S_JALR: begin
        bus.alu_src_a_o  = ALU_A_RS1;
        bus.alu_src_b_o  = ALU_B_IMM;
        bus.imm_src_o    = IMM_I;
        bus.result_src_o = RES_ALU;
        bus.pc_write_o   = 1'b1;
      end
      S_JALR_WB: begin
        bus.alu_src_a_o  = ALU_A_OLDPC;
        bus.alu_src_b_o  = ALU_B_FOUR;
        bus.result_src_o = RES_ALU;
        bus.reg_write_o  = 1'b1;
      end
      default: ;
    endcase
  end

  // Wait timer restarts on every state change and counts stalled cycles
  mc_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (state_d != state_q),
    .en_i   (is_wait_state(state_q) && !bus.mem_ready_i),
    .flag_o (wait_flag)
  );

  // Sticky memory-timeout record, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni)        err_q <= 1'b0;
    else if (wait_flag) err_q <= 1'b1;
  end

  assign bus.mem_err_o = err_q | wait_flag;
  assign bus.state_o   = state_q;

`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal_o = (state_q == S_TRAP);
`else
  assign bus.illegal_o = 1'b0;
`endif

endmodule
